// File: rtl/ripple_mon_pkg.sv
// Shared types and defaults for the ripple counter monitor.
package ripple_mon_pkg;

    localparam int CNT_W  = 4;
    localparam int SYNC_N = 2;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// Per-bit multi-flop synchronizer bringing an asynchronous bus into the clk domain.
module sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_monitor.sv
// Synchronizes a ripple counter, accepts only values seen on two consecutive cycles,
// and reports matches, wraps and non-unit steps of the accepted count.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH       = CNT_W,
    parameter int SYNC_STAGES = SYNC_N,
    parameter int WRAP_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic [WIDTH-1:0]      match_val,
    input  logic                  match_en,
    input  logic                  clr,
    output logic [WIDTH-1:0]      cnt_out,
    output logic                  cnt_valid,
    output logic                  match_pulse,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  step_err
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  p;
    logic [WIDTH-1:0]  delta;
    logic [FILL_W-1:0] fill;
    logic              primed;
    logic              stable;
    logic              changed;
    logic              is_wrap;
    state_t            state;

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_in),
        .q     (s)
    );

    // The zeros left in the chain by reset are not real samples, so stability is
    // only trusted once both s and p hold values sampled after reset released.
    assign primed  = (fill == FILL_DONE);
    assign stable  = primed && (s == p);
    assign changed = (state == ST_TRACK) && stable && (s != cnt_out);
    assign is_wrap = (s < cnt_out);
    assign delta   = s - cnt_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            p           <= '0;
            fill        <= '0;
            state       <= ST_INIT;
            cnt_out     <= '0;
            cnt_valid   <= 1'b0;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            step_err    <= 1'b0;
        end else begin
            p           <= s;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            if (!primed) begin
                fill <= fill + 1'b1;
            end

            case (state)
                ST_INIT: begin
                    if (stable) begin
                        cnt_out   <= s;
                        cnt_valid <= 1'b1;
                        state     <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (changed) begin
                        cnt_out     <= s;
                        wrap_pulse  <= is_wrap;
                        match_pulse <= match_en && (s == match_val);
                    end
                end
                default: state <= ST_INIT;
            endcase

            // clr wins over a wrap or bad step landing on the same edge.
            if (clr) begin
                wrap_count <= '0;
                step_err   <= 1'b0;
            end else begin
                if (changed && is_wrap && (wrap_count != '1)) begin
                    wrap_count <= wrap_count + 1'b1;
                end
                if (changed && (delta != WIDTH'(1))) begin
                    step_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Randomized and directed bench for ripple_count_monitor against a sample-history model.
module tb_ripple_count_monitor;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int WRAP_CNT_W  = 8;
    localparam int DEPTH       = SYNC_STAGES + 2;
    localparam int MODV        = 1 << WIDTH;
    localparam int WRAP_MAX    = (1 << WRAP_CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [WIDTH-1:0]      cnt_in;
    logic [WIDTH-1:0]      match_val;
    logic                  match_en;
    logic                  clr;
    logic [WIDTH-1:0]      cnt_out;
    logic                  cnt_valid;
    logic                  match_pulse;
    logic                  wrap_pulse;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic                  step_err;

    int checks = 0;
    int errors = 0;

    int hist[$];
    bit m_valid;
    int m_cnt;
    int m_wrap_count;
    bit m_step_err;
    bit m_wrap_pulse;
    bit m_match_pulse;

    int obs_updates;
    int obs_wraps;
    int obs_matches;
    int obs_match_cnt;
    int prev_cnt;

    always #5 clk = ~clk;

    ripple_count_monitor #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .WRAP_CNT_W  (WRAP_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_in      (cnt_in),
        .match_val   (match_val),
        .match_en    (match_en),
        .clr         (clr),
        .cnt_out     (cnt_out),
        .cnt_valid   (cnt_valid),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .step_err    (step_err)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // A value is accepted once the samples taken SYNC_STAGES and SYNC_STAGES+1 edges ago agree.
    function automatic void modelEdge();
        int  s;
        int  p;
        bit  bad;
        if (reset) begin
            hist.delete();
            m_valid       = 0;
            m_cnt         = 0;
            m_wrap_count  = 0;
            m_step_err    = 0;
            m_wrap_pulse  = 0;
            m_match_pulse = 0;
            return;
        end
        m_wrap_pulse  = 0;
        m_match_pulse = 0;
        bad           = 0;
        hist.push_back(int'(cnt_in));
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (hist.size() == DEPTH) begin
            s = hist[DEPTH-1-SYNC_STAGES];
            p = hist[DEPTH-2-SYNC_STAGES];
            if (s == p) begin
                if (!m_valid) begin
                    m_valid = 1;
                    m_cnt   = s;
                end else if (s != m_cnt) begin
                    m_wrap_pulse  = (s < m_cnt);
                    m_match_pulse = match_en && (s == int'(match_val));
                    bad           = (((s - m_cnt) + MODV) % MODV) != 1;
                    m_cnt         = s;
                end
            end
        end
        if (clr) begin
            m_wrap_count = 0;
            m_step_err   = 0;
        end else begin
            if (m_wrap_pulse && m_wrap_count < WRAP_MAX) m_wrap_count++;
            if (bad) m_step_err = 1;
        end
    endfunction

    task automatic applyStimulus(input int value, input bit en, input int mval,
                                 input bit clear, input bit rst);
        cnt_in    = WIDTH'(value);
        match_en  = en;
        match_val = WIDTH'(mval);
        clr       = clear;
        reset     = rst;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("cnt_out",     int'(cnt_out),     m_cnt);
        checkOutput("cnt_valid",   int'(cnt_valid),   int'(m_valid));
        checkOutput("wrap_pulse",  int'(wrap_pulse),  int'(m_wrap_pulse));
        checkOutput("match_pulse", int'(match_pulse), int'(m_match_pulse));
        checkOutput("wrap_count",  int'(wrap_count),  m_wrap_count);
        checkOutput("step_err",    int'(step_err),    int'(m_step_err));
        if (int'(cnt_out) != prev_cnt) obs_updates++;
        if (wrap_pulse) obs_wraps++;
        if (match_pulse) begin
            obs_matches++;
            obs_match_cnt = int'(cnt_out);
        end
        prev_cnt = int'(cnt_out);
    endtask

    task automatic holdValue(input int value, input int cycles, input bit en, input int mval);
        for (int i = 0; i < cycles; i++) applyStimulus(value, en, mval, 1'b0, 1'b0);
    endtask

    task automatic clearObs();
        obs_updates   = 0;
        obs_wraps     = 0;
        obs_matches   = 0;
        obs_match_cnt = -1;
    endtask

    initial begin
        int val;
        int mode;
        int hold;
        bit en;
        int mval;

        prev_cnt = 0;
        clearObs();

        // First acquisition after reset lands on the fourth edge.
        applyStimulus(5, 0, 0, 0, 1);
        applyStimulus(5, 0, 0, 0, 1);
        checkOutput("reset_cnt_out", int'(cnt_out), 0);
        checkOutput("reset_valid", int'(cnt_valid), 0);
        clearObs();
        for (int i = 0; i < 3; i++) applyStimulus(5, 0, 0, 0, 0);
        checkOutput("acq_wait_valid", int'(cnt_valid), 0);
        applyStimulus(5, 0, 0, 0, 0);
        checkOutput("acq_cnt_out", int'(cnt_out), 5);
        checkOutput("acq_valid", int'(cnt_valid), 1);
        checkOutput("acq_no_pulses", obs_wraps + obs_matches, 0);
        checkOutput("acq_step_err", int'(step_err), 0);

        // Full count 0..15 then wrap to 0.
        applyStimulus(0, 0, 0, 0, 1);
        holdValue(0, 6, 0, 0);
        clearObs();
        for (int v = 1; v < 16; v++) holdValue(v, 6, 0, 0);
        checkOutput("seq_updates", obs_updates, 15);
        checkOutput("seq_step_err", int'(step_err), 0);
        checkOutput("seq_no_wrap", obs_wraps, 0);
        holdValue(0, 6, 0, 0);
        checkOutput("seq_wrap_pulses", obs_wraps, 1);
        checkOutput("seq_wrap_count", int'(wrap_count), 1);

        // Single-cycle glitch is filtered.
        holdValue(3, 5, 0, 0);
        applyStimulus(3, 0, 0, 1, 0);
        clearObs();
        applyStimulus(7, 0, 0, 0, 0);
        holdValue(3, 6, 0, 0);
        checkOutput("glitch_cnt_out", int'(cnt_out), 3);
        checkOutput("glitch_events", obs_updates + obs_wraps + obs_matches, 0);
        checkOutput("glitch_step_err", int'(step_err), 0);

        // Match pulse with and without enable.
        holdValue(8, 6, 1, 9);
        clearObs();
        holdValue(9, 6, 1, 9);
        checkOutput("match_pulses", obs_matches, 1);
        checkOutput("match_coincident_cnt", obs_match_cnt, 9);
        holdValue(8, 6, 0, 9);
        clearObs();
        holdValue(9, 6, 0, 9);
        checkOutput("match_disabled", obs_matches, 0);

        // Skip sets sticky error; clr on the wrap edge wins over wrap and error.
        holdValue(2, 5, 0, 0);
        applyStimulus(2, 0, 0, 1, 0);
        holdValue(5, 6, 0, 0);
        checkOutput("skip_step_err", int'(step_err), 1);
        holdValue(15, 6, 0, 0);
        checkOutput("skip_sticky", int'(step_err), 1);
        holdValue(0, 3, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("clr_wrap_pulse", int'(wrap_pulse), 1);
        checkOutput("clr_wrap_count", int'(wrap_count), 0);
        checkOutput("clr_step_err", int'(step_err), 0);
        holdValue(0, 2, 0, 0);

        // Saturation of the wrap counter.
        applyStimulus(15, 0, 0, 0, 1);
        holdValue(15, 6, 0, 0);
        for (int w = 0; w < 300; w++) begin
            holdValue(0, 3, 0, 0);
            holdValue(15, 3, 0, 0);
        end
        checkOutput("wrap_saturate", int'(wrap_count), WRAP_MAX);

        // Reset mid-count then re-acquire.
        applyStimulus(15, 0, 0, 0, 1);
        checkOutput("midrst_cnt_out", int'(cnt_out), 0);
        checkOutput("midrst_valid", int'(cnt_valid), 0);
        checkOutput("midrst_wrap_count", int'(wrap_count), 0);
        checkOutput("midrst_step_err", int'(step_err), 0);
        holdValue(15, 3, 0, 0);
        checkOutput("reacq_wait_valid", int'(cnt_valid), 0);
        holdValue(15, 1, 0, 0);
        checkOutput("reacq_valid", int'(cnt_valid), 1);
        checkOutput("reacq_cnt_out", int'(cnt_out), 15);

        // Randomized ripple-like traffic with glitches, clears and resets.
        val = 15;
        for (int r = 0; r < 400; r++) begin
            mode = $urandom_range(0, 9);
            en   = 1'($urandom_range(0, 1));
            mval = $urandom_range(0, MODV - 1);
            if (mode < 6) begin
                val = (val + 1) % MODV;
            end else if (mode < 8) begin
                val = $urandom_range(0, MODV - 1);
            end else begin
                applyStimulus($urandom_range(0, MODV - 1), en, mval, 1'b0, 1'b0);
            end
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) begin
                applyStimulus(val, en, mval,
                              ($urandom_range(0, 19) == 0),
                              ($urandom_range(0, 149) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
